// File: rtl/apb_pkg.sv
// Shared definitions for the 8-bit APB requester: FSM states, default bus widths
// and the timeout-counter width helper.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 8;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

  // Bits needed to count 0 .. cycles-1; never narrower than one bit.
  function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase watchdog for apb_master. Counts enabled cycles since the last clear and
// flags the cycle that is the CYCLES-th enabled cycle. Only built with APB_MASTER_TIMEOUT_EN.
module apb_timeout_counter
  import apb_pkg::*;
#(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = timeout_cnt_width(CYCLES);

  logic [CntW-1:0] cnt_q;

  // Count enabled cycles; hold once expired so the value never wraps.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // First enabled cycle sees a count of 0, so the CYCLES-th one sees CYCLES-1.
  assign expired = enable && (cnt_q == CntW'(CYCLES - 1));

endmodule

// File: rtl/apb_master.sv
// APB requester: converts single-beat valid/ready commands into APB SETUP/ACCESS transfers
// and returns read data / error status on a one-cycle response strobe.
// Optional feature: define APB_MASTER_TIMEOUT_EN to bound the ACCESS phase to
// TIMEOUT_CYCLES cycles, completing with an error if pready never arrives.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  // Command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // Response strobe
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // APB requester side
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout_cfg
    $error("apb_master: TIMEOUT_CYCLES must be at least 1");
  end

  apb_state_e state_q;
  logic       timeout;

`ifdef APB_MASTER_TIMEOUT_EN
  logic cnt_clear;
  logic cnt_enable;

  // Clearing throughout SETUP leaves the count at zero on the first ACCESS cycle.
  assign cnt_clear  = (state_q == APB_SETUP);
  assign cnt_enable = (state_q == APB_ACCESS);

  apb_timeout_counter #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Only output not taken from a flop; masked by reset so nothing is accepted then.
  assign cmd_ready = (state_q == APB_IDLE) && !rst;

  // Transfer FSM with registered APB controls and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= APB_IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state_q)
        APB_IDLE: begin
          if (cmd_valid) begin
            pwrite  <= cmd_write;
            paddr   <= cmd_addr;
            pwdata  <= cmd_wdata;
            psel    <= 1'b1;
            state_q <= APB_SETUP;
          end
        end
        APB_SETUP: begin
          penable <= 1'b1;
          state_q <= APB_ACCESS;
        end
        APB_ACCESS: begin
          // A real pready beats a timeout landing in the same cycle.
          if (pready) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state_q   <= APB_IDLE;
          end else if (timeout) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state_q   <= APB_IDLE;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state_q <= APB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: table of single transfers plus hand-written
// reset, mid-transfer reset and long-wait / timeout sequences.
module tb_apb_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata = 8'h00;
  logic       pready = 1'b0;
  logic       pslverr = 1'b0;

  always #5 clk = ~clk;

  apb_master #(
    .ADDR_W         (8),
    .DATA_W         (8),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  typedef struct {
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         waits;     // ACCESS cycles with pready low before completion
    logic [7:0] prdata;
    logic       slverr;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic last;
    chk({tag, " cmd_ready idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    pready    = 1'b0;
    step();  // accept edge N
    // Scramble the command bus: the APB side must keep the latched values.
    cmd_valid = 1'b0;
    cmd_write = ~v.write;
    cmd_addr  = ~v.addr;
    cmd_wdata = ~v.wdata;
    // pready during SETUP must be ignored.
    pready    = 1'b1;
    prdata    = 8'h99;
    pslverr   = 1'b1;
    chk({tag, " setup psel"}, 32'(psel), 32'd1);
    chk({tag, " setup penable"}, 32'(penable), 32'd0);
    chk({tag, " setup paddr"}, 32'(paddr), 32'(v.addr));
    chk({tag, " setup pwrite"}, 32'(pwrite), 32'(v.write));
    chk({tag, " setup pwdata"}, 32'(pwdata), 32'(v.wdata));
    chk({tag, " setup cmd_ready"}, 32'(cmd_ready), 32'd0);
    step();
    for (int w = 0; w <= v.waits; w++) begin
      last    = (w == v.waits);
      pready  = last;
      prdata  = last ? v.prdata : 8'h66;
      pslverr = last ? v.slverr : 1'b1;
      chk({tag, " access psel"}, 32'(psel), 32'd1);
      chk({tag, " access penable"}, 32'(penable), 32'd1);
      chk({tag, " access paddr"}, 32'(paddr), 32'(v.addr));
      chk({tag, " access pwdata"}, 32'(pwdata), 32'(v.wdata));
      chk({tag, " access pwrite"}, 32'(pwrite), 32'(v.write));
      chk({tag, " access rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, " access cmd_ready"}, 32'(cmd_ready), 32'd0);
      step();
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 8'h00;
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'(v.exp_rdata));
    chk({tag, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
    chk({tag, " done psel"}, 32'(psel), 32'd0);
    chk({tag, " done penable"}, 32'(penable), 32'd0);
    chk({tag, " done cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, " done paddr hold"}, 32'(paddr), 32'(v.addr));
    step();
    chk({tag, " rsp_valid single"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    vec_t long_v;
    //         write addr   wdata  waits prdata slverr exp_rdata exp_err
    vecs[0] = '{1'b1, 8'h02, 8'hFF, 0, 8'h3C, 1'b0, 8'h00, 1'b0};  // zero-wait write
    vecs[1] = '{1'b0, 8'h02, 8'h00, 3, 8'hFF, 1'b0, 8'hFF, 1'b0};  // wait-state read
    vecs[2] = '{1'b1, 8'h05, 8'hA5, 0, 8'h3C, 1'b1, 8'h00, 1'b1};  // slave error write
    vecs[3] = '{1'b0, 8'h10, 8'h00, 0, 8'h5A, 1'b0, 8'h5A, 1'b0};  // read after error
    vecs[4] = '{1'b0, 8'h7F, 8'h11, 1, 8'hC3, 1'b1, 8'hC3, 1'b1};  // read with error

    // Reset held for two cycles with a pending command.
    cmd_valid = 1'b1;
    cmd_addr  = 8'hAA;
    cmd_wdata = 8'h55;
    cmd_write = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("reset cmd_ready", 32'(cmd_ready), 32'd0);
      chk("reset psel", 32'(psel), 32'd0);
      chk("reset penable", 32'(penable), 32'd0);
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    end
    chk("reset paddr", 32'(paddr), 32'd0);
    chk("reset pwdata", 32'(pwdata), 32'd0);
    chk("reset pwrite", 32'(pwrite), 32'd0);
    chk("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    rst       = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("post-reset cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    chk("idle psel", 32'(psel), 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a wait state aborts without a response.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h33;
    pready    = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    chk("abort access penable", 32'(penable), 32'd1);
    step();
    rst = 1'b1;
    step();
    chk("abort psel", 32'(psel), 32'd0);
    chk("abort penable", 32'(penable), 32'd0);
    chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort cmd_ready in reset", 32'(cmd_ready), 32'd0);
    rst     = 1'b0;
    pready  = 1'b1;
    prdata  = 8'h77;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort no rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort stays idle", 32'(psel), 32'd0);
    end
    pready = 1'b0;
    prdata = 8'h00;
    run_txn(vecs[3], "after-abort");

`ifdef APB_MASTER_TIMEOUT_EN
    // pready never arrives: completes with an error after 4 ACCESS cycles.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h44;
    step();
    cmd_valid = 1'b0;
    prdata    = 8'hEE;
    pslverr   = 1'b0;
    pready    = 1'b0;
    step();
    for (int w = 0; w < 4; w++) begin
      chk("timeout wait rsp_valid", 32'(rsp_valid), 32'd0);
      chk("timeout wait psel", 32'(psel), 32'd1);
      step();
    end
    chk("timeout rsp_valid", 32'(rsp_valid), 32'd1);
    chk("timeout rsp_err", 32'(rsp_err), 32'd1);
    chk("timeout rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("timeout psel", 32'(psel), 32'd0);
    chk("timeout penable", 32'(penable), 32'd0);
    chk("timeout cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    chk("timeout rsp_valid single", 32'(rsp_valid), 32'd0);
    prdata = 8'h00;
`else
    // Without the watchdog a long stall still completes normally.
    long_v = '{1'b0, 8'h21, 8'h00, 20, 8'h9D, 1'b0, 8'h9D, 1'b0};
    run_txn(long_v, "long-wait");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

Requester end of the team's 8-bit APB bus: it turns single-beat commands from a local valid/ready port into APB SETUP/ACCESS transfers. It drives `APB_slave`-style responders and returns read data and error status on a one-cycle response strobe. It sits between a controller/sequencer and one or more APB slaves (decode is external).

## Interface
- `ADDR_W`, 8, APB address width
- `DATA_W`, 8, APB data width
- `TIMEOUT_CYCLES`, 16, maximum ACCESS cycles waiting for `pready` (used only with the timeout feature)

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  target address
- `cmd_wdata`  in  DATA_W  write data
- `rsp_valid`  out  1  one-cycle completion strobe
- `rsp_rdata`  out  DATA_W  read data (0 for writes)
- `rsp_err`  out  1  transfer error
- `psel`, `penable`, `pwrite`  out  1  APB control
- `paddr`  out  ADDR_W; `pwdata`  out  DATA_W
- `prdata`  in  DATA_W; `pready`  in  1; `pslverr`  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: `cmd_ready` = 1. On handshake, the block latches write, addr, and wdata into `pwrite`/`paddr`/`pwdata`, then moves to SETUP.
- SETUP: `psel` = 1, `penable` = 0 for exactly one cycle, then moves to ACCESS.
- ACCESS: `psel` = 1, `penable` = 1. The block holds this state while `pready` = 0. When `pready` = 1 is sampled, the block:
  - registers `rsp_rdata` = `prdata` for reads, or 0 for writes;
  - registers `rsp_err` = `pslverr`;
  - pulses `rsp_valid`;
  - clears `psel` and `penable`;
  - returns to IDLE.
- `pslverr` and `prdata` are ignored while `pready` = 0.
- `paddr`, `pwrite`, and `pwdata` stay stable from SETUP through ACCESS completion, then hold their last values until the next accept.
- `cmd_ready` = (state == IDLE) && !`rst`. It is never high in SETUP or ACCESS, so no command is lost or duplicated.
- Reset values (any cycle `rst` is sampled high):
  - state = IDLE;
  - `psel` = `penable` = `pwrite` = 0, `paddr` = `pwdata` = 0;
  - `rsp_valid` = `rsp_err` = 0, `rsp_rdata` = 0.
- Reset mid-transfer aborts the transfer: APB control drops at the next edge and no `rsp_valid` is issued.

## Timing
- Command accepted at edge N:
  - SETUP during cycle N+1;
  - ACCESS from cycle N+2.
- With zero wait states (`pready` = 1 in the first ACCESS cycle), `rsp_valid` = 1 in cycle N+3, and `cmd_ready` is high again in cycle N+3.
- Each wait cycle (`pready` = 0) delays the response by one cycle.
- Minimum spacing between accepted commands is 3 cycles.
- `rsp_valid` is a single-cycle pulse with no back-pressure; the consumer must take it.
- All outputs except `cmd_ready` come straight from flops.

## Configuration
- Macro: `APB_MASTER_TIMEOUT_EN`.
- Defined:
  - A counter runs during ACCESS, cleared on entry to ACCESS.
  - If `pready` is still 0 in the `TIMEOUT_CYCLES`-th ACCESS cycle, the block completes the transfer anyway with `rsp_valid` = 1, `rsp_err` = 1, `rsp_rdata` = 0, drops `psel`/`penable`, and returns to IDLE.
  - If `pready` = 1 arrives in that same cycle, the normal completion wins.
- Undefined: no counter is built, and ACCESS waits indefinitely for `pready`.

## Structure
- Shared package `apb_pkg`:
  - state enum (`APB_IDLE`, `APB_SETUP`, `APB_ACCESS`);
  - default `ADDR_W`/`DATA_W` constants;
  - timeout-counter width derived from `TIMEOUT_CYCLES`.
- One sub-module, `apb_timeout_counter` (clear/enable/expired). It is instantiated only under `APB_MASTER_TIMEOUT_EN`.
- The FSM and datapath stay in `apb_master`.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles while `cmd_valid` = 1 → `cmd_ready` = 0, `psel` = `penable` = 0, no `rsp_valid`. After release, `cmd_ready` = 1.
- Zero-wait write: addr 8'h02, wdata 8'hFF, `pready` tied 1 → SETUP then ACCESS with `paddr` = 8'h02, `pwdata` = 8'hFF, `pwrite` = 1. `rsp_valid` at accept+3 with `rsp_rdata` = 0, `rsp_err` = 0.
- Wait-state read: addr 8'h02, `pready` low for 3 ACCESS cycles, then high with `prdata` = 8'hFF → ACCESS lasts 4 cycles with stable APB outputs. `rsp_rdata` = 8'hFF at accept+6.
- Slave error: write to 8'h05, with `pready` = 1 and `pslverr` = 1 on completion → `rsp_err` = 1. The next command is accepted normally.
- Reset mid-ACCESS: assert `rst` during a wait state → `psel`/`penable` are 0 at the next edge and no `rsp_valid` is ever issued.
- Timeout (macro defined, `TIMEOUT_CYCLES` = 4): `pready` held 0 → after 4 ACCESS cycles, `rsp_valid` = 1, `rsp_err` = 1, `rsp_rdata` = 0, and `psel` drops.
